uart_param: RTL and testbench

- Parametrised full-duplex UART; next generation of the fixed 8N1 `uart` block.
- Configurable clock/baud, data width, parity mode and stop-bit count.
- Adds RX error reporting (parity, framing, overrun), start-bit glitch rejection and an asynchronous reset.
- Sits between the system bus logic and the FPGA serial pins; same `wr_en`/`Tx_busy` and `ready`/`ready_clr` handshake as `uart`.

---
 rtl/uart_param.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
`default_nettype none
// ============================================================================
// uart_param : parametrised full-duplex UART with parity, RX error flags
// Rev 1.0
// ============================================================================
module uart_param #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk_50m,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 wr_en,
   output logic                 Tx,
   output logic                 Tx_busy,
   input  logic                 Rx,
   output logic                 ready,
   input  logic                 ready_clr,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int c_tx_div = CLK_FREQ / BAUD;
   localparam int c_rx_div = CLK_FREQ / (16 * BAUD);
   localparam int c_txw    = (c_tx_div > 1) ? $clog2(c_tx_div) : 1;
   localparam int c_rxw    = (c_rx_div > 1) ? $clog2(c_rx_div) : 1;

   localparam logic [c_txw-1:0] c_tx_last   = c_txw'(c_tx_div - 1);
   localparam logic [c_rxw-1:0] c_rx_last   = c_rxw'(c_rx_div - 1);
   localparam logic [3:0]       c_last_bit  = 4'(DATA_BITS - 1);
   localparam logic             c_last_stop = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ---------------- transmitter ----------------
   state_t                 tx_state_q, tx_state_d;
   logic [c_txw-1:0]       tx_div_q, tx_div_d;
   logic [3:0]             tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
   logic                   tx_par_q, tx_par_d;
   logic                   tx_stop_q, tx_stop_d;
   logic                   tx_tick;

   assign tx_tick = (tx_div_q == c_tx_last);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_stop_d  = tx_stop_q;
      if (tx_state_q != S_IDLE) begin
         tx_div_d = tx_tick ? '0 : tx_div_q + 1'b1;
      end
      case (tx_state_q)
         S_IDLE: begin
            if (wr_en) begin
               tx_shift_d = data_in;
               tx_par_d   = (PARITY == 1) ? ~(^data_in) : (^data_in);
               tx_div_d   = '0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_tick) begin
               tx_bit_d   = '0;
               tx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_tick) begin
               tx_shift_d = tx_shift_q >> 1;
               if (tx_bit_q == c_last_bit) begin
                  tx_stop_d  = 1'b0;
                  tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (tx_tick) begin
               tx_stop_d  = 1'b0;
               tx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tx_tick) begin
               if (tx_stop_q == c_last_stop) begin
                  tx_state_d = S_IDLE;
               end else begin
                  tx_stop_d = 1'b1;
               end
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         tx_state_q <= S_IDLE;
         tx_div_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_stop_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_stop_q  <= tx_stop_d;
      end
   end

   // Line level decoded from state so an async reset forces idle-high at once
   always_comb begin
      Tx = 1'b1;
      case (tx_state_q)
         S_START:  Tx = 1'b0;
         S_DATA:   Tx = tx_shift_q[0];
         S_PARITY: Tx = tx_par_q;
         default:  Tx = 1'b1;
      endcase
   end

   assign Tx_busy = (tx_state_q != S_IDLE);

   // ---------------- receiver ----------------
   logic                   rx_meta_q, rx_sync_q;
   state_t                 rx_state_q, rx_state_d;
   logic [c_rxw-1:0]       rx_os_q, rx_os_d;
   logic [3:0]             rx_tk_q, rx_tk_d;
   logic [3:0]             rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
   logic                   rx_par_q, rx_par_d;
   logic                   ready_q, ready_d;
   logic [DATA_BITS-1:0]   data_out_q, data_out_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;
   logic                   os_tick;
   logic                   bit_sample;
   logic                   rx_par_exp;

   assign os_tick    = (rx_os_q == c_rx_last);
   assign bit_sample = os_tick && (rx_tk_q == 4'd15);
   assign rx_par_exp = (PARITY == 1) ? ~(^rx_shift_q) : (^rx_shift_q);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_os_d    = rx_os_q;
      rx_tk_d    = rx_tk_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      ready_d    = ready_q;
      data_out_d = data_out_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      ovr_d      = ovr_q;
      if (ready_clr) begin
         ready_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
         ovr_d   = 1'b0;
      end
      if (rx_state_q == S_IDLE) begin
         rx_os_d = '0;
         rx_tk_d = '0;
      end else begin
         rx_os_d = os_tick ? '0 : rx_os_q + 1'b1;
         if (os_tick) begin
            rx_tk_d = rx_tk_q + 1'b1;
         end
      end
      case (rx_state_q)
         S_IDLE: begin
            if (!rx_sync_q) begin
               rx_state_d = S_START;
            end
         end
         S_START: begin
            // Half-bit check; a line back high by now was only a glitch
            if (os_tick && (rx_tk_q == 4'd7)) begin
               rx_tk_d    = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (bit_sample) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == c_last_bit) begin
                  rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_sample) begin
               rx_par_d   = rx_sync_q;
               rx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_sample) begin
               rx_state_d = S_IDLE;
               data_out_d = rx_shift_q;
               ready_d    = 1'b1;
               perr_d     = (PARITY != 0) && (rx_par_q != rx_par_exp);
               ferr_d     = ~rx_sync_q;
               if (ready_q && !ready_clr) begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_os_q    <= '0;
         rx_tk_q    <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         ready_q    <= 1'b0;
         data_out_q <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rx_meta_q  <= Rx;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_os_q    <= rx_os_d;
         rx_tk_q    <= rx_tk_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         ready_q    <= ready_d;
         data_out_q <= data_out_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign ready      = ready_q;
   assign data_out   = data_out_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_param.sv
`default_nettype none
// ============================================================================
// tb_uart_param : directed bench for uart_param (three parity configurations)
// Rev 1.0
// ============================================================================
module tb_uart_param;

   logic clk_50m = 1'b0;
   always #5 clk_50m = ~clk_50m;

   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   logic       lb;
   logic       rx_line;
   logic [1:0] tgt;

   logic [7:0] din0, dout0, din1, dout1, din2, dout2;
   logic wr0, tx0, busy0, rx0, rdy0, clr0, pe0, fe0, ov0;
   logic wr1, tx1, busy1, rx1, rdy1, clr1, pe1, fe1, ov1;
   logic wr2, tx2, busy2, rx2, rdy2, clr2, pe2, fe2, ov2;

   assign rx0 = lb ? tx0 : ((tgt == 2'd0) ? rx_line : 1'b1);
   assign rx1 = (tgt == 2'd1) ? rx_line : 1'b1;
   assign rx2 = tx2;

   uart_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_p0 (
      .clk_50m(clk_50m), .rst(rst), .data_in(din0), .wr_en(wr0), .Tx(tx0), .Tx_busy(busy0),
      .Rx(rx0), .ready(rdy0), .ready_clr(clr0), .data_out(dout0),
      .parity_err(pe0), .frame_err(fe0), .overrun(ov0));

   uart_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_p1 (
      .clk_50m(clk_50m), .rst(rst), .data_in(din1), .wr_en(wr1), .Tx(tx1), .Tx_busy(busy1),
      .Rx(rx1), .ready(rdy1), .ready_clr(clr1), .data_out(dout1),
      .parity_err(pe1), .frame_err(fe1), .overrun(ov1));

   uart_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_p2 (
      .clk_50m(clk_50m), .rst(rst), .data_in(din2), .wr_en(wr2), .Tx(tx2), .Tx_busy(busy2),
      .Rx(rx2), .ready(rdy2), .ready_clr(clr2), .data_out(dout2),
      .parity_err(pe2), .frame_err(fe2), .overrun(ov2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_50m);
         #1;
      end
   endtask

   // Drives one frame on rx_line, 16 cycles per bit; optionally pulses
   // clr0 in the cycle whose closing edge is the stop-bit sample (8N1).
   task automatic rx_send(input logic [7:0] d, input bit has_par, input logic pbit,
                          input logic sbit, input bit clr_hit);
      rx_line = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         rx_line = d[i];
         tick(16);
      end
      if (has_par) begin
         rx_line = pbit;
         tick(16);
      end
      rx_line = sbit;
      if (clr_hit) begin
         tick(10);
         clr0 = 1'b1;
         tick(1);
         clr0 = 1'b0;
         tick(5);
      end else begin
         tick(16);
      end
      rx_line = 1'b1;
      tick(16);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] exp_tx;
      int k;
      int rdy_cnt;
      int busy_cnt;

      rst = 1'b1;
      lb = 1'b1; tgt = 2'd0; rx_line = 1'b1;
      din0 = '0; wr0 = 1'b0; clr0 = 1'b0;
      din1 = '0; wr1 = 1'b0; clr1 = 1'b0;
      din2 = '0; wr2 = 1'b0; clr2 = 1'b0;
      tick(3);
      chk("rst_tx", tx0, 1);
      chk("rst_busy", busy0, 0);
      chk("rst_ready", rdy0, 0);
      chk("rst_dout", dout0, 0);
      chk("rst_flags", {pe0, fe0, ov0}, 0);
      chk("rst_p1", {tx1, busy1, rdy1, pe1, fe1, ov1}, 6'b100000);
      rst = 1'b0;
      tick(2);
      chk("post_rst", {tx0, busy0, rdy0}, 3'b100);

      // Loopback 0x00..0x0F, no parity
      rdy_cnt = 0;
      for (int b = 0; b < 16; b++) begin
         k = 0;
         while (busy0 && k < 400) begin tick(1); k++; end
         din0 = 8'(b);
         wr0 = 1'b1;
         tick(1);
         wr0 = 1'b0;
         k = 0;
         while (!rdy0 && k < 400) begin tick(1); k++; end
         chk("lb_ready", rdy0, 1);
         if (rdy0) rdy_cnt++;
         chk("lb_data", dout0, b);
         chk("lb_flags", {pe0, fe0, ov0}, 0);
         clr0 = 1'b1;
         tick(1);
         clr0 = 1'b0;
         chk("lb_clr", rdy0, 0);
      end
      chk("lb_count", rdy_cnt, 16);
      k = 0;
      while (busy0 && k < 400) begin tick(1); k++; end
      lb = 1'b0;

      // Even-parity TX waveform of 0xAB with a mid-frame write attempt
      exp_tx = 11'h756;
      busy_cnt = 0;
      din2 = 8'hAB;
      wr2 = 1'b1;
      tick(1);
      wr2 = 1'b0;
      for (int i = 0; i < 176; i++) begin
         if (i == 40) begin din2 = 8'h00; wr2 = 1'b1; end
         if (i == 41) wr2 = 1'b0;
         if (busy2) busy_cnt++;
         if ((i % 16) == 0 || (i % 16) == 15)
            chk($sformatf("tx_bit%0d_c%0d", i / 16, i), tx2, exp_tx[i / 16]);
         tick(1);
      end
      chk("tx_busy_cycles", busy_cnt, 176);
      chk("tx_done", {busy2, tx2}, 2'b01);
      chk("tx_lb_rx", {rdy2, pe2, fe2}, 3'b100);
      chk("tx_lb_data", dout2, 8'hAB);

      // Odd-parity receiver fed a wrong parity bit
      tgt = 2'd1;
      rx_send(8'hAB, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("par_ready", rdy1, 1);
      chk("par_data", dout1, 8'hAB);
      chk("par_perr", pe1, 1);
      chk("par_ferr", fe1, 0);

      // Framing error then clear
      tgt = 2'd0;
      rx_send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fe_ready", rdy0, 1);
      chk("fe_ferr", fe0, 1);
      chk("fe_data", dout0, 8'h55);
      chk("fe_perr", pe0, 0);
      clr0 = 1'b1;
      tick(1);
      clr0 = 1'b0;
      chk("fe_clr", {rdy0, pe0, fe0, ov0}, 0);

      // Overrun, then ready_clr coinciding with a completion
      rx_send(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ov_first", {rdy0, ov0}, 2'b10);
      rx_send(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ov_set", ov0, 1);
      chk("ov_data", dout0, 8'h22);
      chk("ov_ready", rdy0, 1);
      rx_send(8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("coin_ready", rdy0, 1);
      chk("coin_ovr", ov0, 0);
      chk("coin_data", dout0, 8'h33);
      clr0 = 1'b1;
      tick(1);
      clr0 = 1'b0;

      // Short low glitch must not produce a frame
      rx_line = 1'b0;
      tick(5);
      rx_line = 1'b1;
      tick(40);
      chk("glitch_ready", rdy0, 0);
      chk("glitch_flags", {pe0, fe0, ov0}, 0);

      // Asynchronous reset in the middle of a transmission
      din0 = 8'hF0;
      wr0 = 1'b1;
      tick(1);
      wr0 = 1'b0;
      tick(30);
      chk("mid_busy", busy0, 1);
      chk("mid_tx", tx0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_tx", tx0, 1);
      chk("arst_busy", busy0, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
